// File: rtl/glift_taint_reg_sink_pkg.sv
// Shared GLIFT definitions: checker FSM states and the per-bit mux taint rule.
// Pure declarations with no latency and no backpressure.
package glift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ALARM = 1'b1
  } sink_state_e;

  // Exact GLIFT taint of (s ? b : a). A tainted select leaks whenever the two
  // candidate values differ, or whenever either candidate is itself tainted.
  function automatic logic glift_mux_t(
    input logic s,
    input logic s_t,
    input logic a,
    input logic a_t,
    input logic b,
    input logic b_t
  );
    return (s & b_t) | (~s & a_t) | (s_t & (a ^ b)) | (s_t & a_t) | (s_t & b_t);
  endfunction

endpackage

// File: rtl/glift_taint_reg_sink_if.sv
// Bundles the data/taint pipeline inputs with the sink checker outputs.
// Wires only: no latency and no backpressure.
interface glift_taint_reg_sink_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] d_t;
  logic             en;
  logic             en_t;
  logic             chk;
  logic             clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_t;
  logic             alarm;
  logic [WIDTH-1:0] leak_mask;
  logic [CNT_W-1:0] vcount;

  modport master (
    output d, d_t, en, en_t, chk, clr,
    input  q, q_t, alarm, leak_mask, vcount
  );

  modport slave (
    input  d, d_t, en, en_t, chk, clr,
    output q, q_t, alarm, leak_mask, vcount
  );

endinterface

// File: rtl/glift_taint_reg_sink_dff_en.sv
// WIDTH-wide GLIFT enabled register: data loads on en, taint follows the mux rule.
// One cycle of latency; no backpressure, the enable alone decides loading.
module glift_dff_en
  import glift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_d_t,
  input  logic             i_en,
  input  logic             i_en_t,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_t
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_t;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_q_t_nxt;

  // The held value is the mux "a" leg and the incoming data the "b" leg.
  always_comb begin
    w_q_nxt   = i_en ? i_d : r_q;
    w_q_t_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_q_t_nxt[i] = glift_mux_t(i_en, i_en_t, r_q[i], r_q_t[i], i_d[i], i_d_t[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_q_t <= '0;
    end else begin
      r_q   <= w_q_nxt;
      r_q_t <= w_q_t_nxt;
    end
  end

  assign o_q   = r_q;
  assign o_q_t = r_q_t;

endmodule

// File: rtl/glift_taint_reg_sink.sv
// GLIFT register pipeline feeding an untrusted sink with a sticky taint alarm.
// DEPTH cycles d->q; alarm/leak_mask/vcount one cycle after chk; no backpressure.
module glift_taint_reg_sink
  import glift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  glift_taint_reg_sink_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] w_s0_dat;
  logic [WIDTH-1:0] w_s0_tnt;
  logic [WIDTH-1:0] w_q_dat;
  logic [WIDTH-1:0] w_q_tnt;

  sink_state_e      r_state;
  sink_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_leak;
  logic [WIDTH-1:0] w_leak_nxt;
  logic [CNT_W-1:0] r_vcount;
  logic [CNT_W-1:0] w_vcount_nxt;
  logic             w_viol;
  logic             w_cnt_inc;

  glift_dff_en #(
    .WIDTH (WIDTH)
  ) u_stage0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (bus.d),
    .i_d_t  (bus.d_t),
    .i_en   (bus.en),
    .i_en_t (bus.en_t),
    .o_q    (w_s0_dat),
    .o_q_t  (w_s0_tnt)
  );

  // Delay stages always load, so taint shifts through untouched.
  if (DEPTH > 1) begin : g_dly
    logic [WIDTH-1:0] r_dat [1:DEPTH-1];
    logic [WIDTH-1:0] r_tnt [1:DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 1; i < DEPTH; i++) begin
          r_dat[i] <= '0;
          r_tnt[i] <= '0;
        end
      end else begin
        r_dat[1] <= w_s0_dat;
        r_tnt[1] <= w_s0_tnt;
        for (int i = 2; i < DEPTH; i++) begin
          r_dat[i] <= r_dat[i-1];
          r_tnt[i] <= r_tnt[i-1];
        end
      end
    end

    assign w_q_dat = r_dat[DEPTH-1];
    assign w_q_tnt = r_tnt[DEPTH-1];
  end else begin : g_nodly
    assign w_q_dat = w_s0_dat;
    assign w_q_tnt = w_s0_tnt;
  end

  assign w_viol = bus.chk & (|w_q_tnt);

  always_comb begin
    w_state_nxt = r_state;
    w_leak_nxt  = r_leak;
    w_cnt_inc   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_viol) begin
          w_state_nxt = ALARM;
          w_leak_nxt  = w_q_tnt;
          w_cnt_inc   = 1'b1;
        end
      end
      ALARM: begin
        // A clear that coincides with a violation re-arms on the fresh taint.
        if (bus.clr) begin
          if (w_viol) begin
            w_leak_nxt = w_q_tnt;
            w_cnt_inc  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_leak_nxt  = '0;
          end
        end else if (w_viol) begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_leak_nxt  = '0;
      end
    endcase
  end

  assign w_vcount_nxt = (w_cnt_inc && (r_vcount != CNT_MAX)) ? r_vcount + CNT_W'(1) : r_vcount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_leak   <= '0;
      r_vcount <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_leak   <= w_leak_nxt;
      r_vcount <= w_vcount_nxt;
    end
  end

  assign bus.q         = w_q_dat;
  assign bus.q_t       = w_q_tnt;
  assign bus.alarm     = (r_state == ALARM);
  assign bus.leak_mask = r_leak;
  assign bus.vcount    = r_vcount;

endmodule

// File: tb/tb_glift_taint_reg_sink.sv
// Bench for glift_taint_reg_sink: directed vector table, corner sequences and a
// randomized run against a queue-based reference model; two DUTs (CNT_W 8 and 2).
module tb_glift_taint_reg_sink;

  localparam int W     = 8;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  glift_taint_reg_sink_if #(.WIDTH(W), .CNT_W(8)) if_a ();
  glift_taint_reg_sink_if #(.WIDTH(W), .CNT_W(2)) if_b ();

  glift_taint_reg_sink #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(8)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  glift_taint_reg_sink #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(2)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] d;
    logic [7:0] dt;
    logic       en;
    logic       ent;
    logic       chk;
    logic       clr;
    logic [7:0] q;
    logic [7:0] qt;
    logic       alarm;
    logic [7:0] leak;
    int         cnt;
  } vec_t;

  vec_t tv[20];

  // Reference model: queue entry 0 is stage 0, the last entry is q.
  logic [7:0] m_d[$];
  logic [7:0] m_t[$];
  bit         m_alarm;
  logic [7:0] m_leak;
  int         m_cnt;

  function automatic vec_t mk(input logic [7:0] d, dt, input logic en, ent, chk, clr,
                              input logic [7:0] q, qt, input logic al, input logic [7:0] lk,
                              input int cnt);
    vec_t v;
    v.d = d; v.dt = dt; v.en = en; v.ent = ent; v.chk = chk; v.clr = clr;
    v.q = q; v.qt = qt; v.alarm = al; v.leak = lk; v.cnt = cnt;
    return v;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] q, qt, input logic al,
                            input logic [7:0] lk, input int cnt);
    cmp({tag, " q"},         32'(if_a.q),         32'(q));
    cmp({tag, " q_t"},       32'(if_a.q_t),       32'(qt));
    cmp({tag, " alarm"},     32'(if_a.alarm),     32'(al));
    cmp({tag, " leak_mask"}, 32'(if_a.leak_mask), 32'(lk));
    cmp({tag, " vcount8"},   32'(if_a.vcount),    32'(sat(cnt, 255)));
    cmp({tag, " vcount2"},   32'(if_b.vcount),    32'(sat(cnt, 3)));
    cmp({tag, " alarm2"},    32'(if_b.alarm),     32'(al));
  endtask

  task automatic drive(input logic [7:0] d, dt, input logic en, ent, chk, clr);
    if_a.d = d; if_a.d_t = dt; if_a.en = en; if_a.en_t = ent; if_a.chk = chk; if_a.clr = clr;
    if_b.d = d; if_b.d_t = dt; if_b.en = en; if_b.en_t = ent; if_b.chk = chk; if_b.clr = clr;
  endtask

  task automatic model_reset();
    m_d = {};
    m_t = {};
    for (int i = 0; i < DEPTH; i++) begin
      m_d.push_back(8'h00);
      m_t.push_back(8'h00);
    end
    m_alarm = 1'b0;
    m_leak  = 8'h00;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [7:0] d, dt, input logic en, ent, chk, clr);
    logic [7:0] r, rt, qt, nr, nt;
    bit         viol;
    r    = m_d[0];
    rt   = m_t[0];
    qt   = m_t[DEPTH-1];
    viol = chk && (qt != 8'h00);
    nr   = en ? d : r;
    nt   = ({8{en}} & dt) | ({8{~en}} & rt) | ({8{ent}} & (r ^ d)) | ({8{ent}} & rt) | ({8{ent}} & dt);
    // Clear takes effect first, then any violation on the current q_t.
    if (clr && m_alarm) begin
      m_alarm = 1'b0;
      m_leak  = 8'h00;
    end
    if (viol) begin
      if (!m_alarm) begin
        m_alarm = 1'b1;
        m_leak  = qt;
      end
      m_cnt++;
    end
    void'(m_d.pop_back());
    void'(m_t.pop_back());
    m_d.push_front(nr);
    m_t.push_front(nt);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            d     dt    en ent chk clr   q     qt   al  leak  cnt
    tv[0]  = mk(8'hA5, 8'h0F, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    tv[1]  = mk(8'h00, 8'hFF, 0, 0, 0, 0, 8'hA5, 8'h0F, 0, 8'h00, 0);
    tv[2]  = mk(8'h00, 8'hFF, 0, 0, 0, 0, 8'hA5, 8'h0F, 0, 8'h00, 0);
    tv[3]  = mk(8'h00, 8'h00, 0, 0, 1, 0, 8'hA5, 8'h0F, 1, 8'h0F, 1);
    tv[4]  = mk(8'h5A, 8'hF0, 1, 0, 0, 0, 8'hA5, 8'h0F, 1, 8'h0F, 1);
    tv[5]  = mk(8'h00, 8'h00, 0, 0, 0, 0, 8'h5A, 8'hF0, 1, 8'h0F, 1);
    tv[6]  = mk(8'h00, 8'h00, 0, 0, 1, 0, 8'h5A, 8'hF0, 1, 8'h0F, 2);
    tv[7]  = mk(8'h00, 8'h00, 0, 0, 0, 1, 8'h5A, 8'hF0, 0, 8'h00, 2);
    tv[8]  = mk(8'h00, 8'h00, 0, 0, 0, 1, 8'h5A, 8'hF0, 0, 8'h00, 2);
    tv[9]  = mk(8'h00, 8'h00, 1, 0, 0, 0, 8'h5A, 8'hF0, 0, 8'h00, 2);
    tv[10] = mk(8'hFF, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2);
    tv[11] = mk(8'h00, 8'h00, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 8'h00, 2);
    tv[12] = mk(8'h0F, 8'h00, 1, 0, 1, 0, 8'hFF, 8'hFF, 1, 8'hFF, 3);
    tv[13] = mk(8'h0F, 8'h00, 1, 1, 0, 0, 8'h0F, 8'h00, 1, 8'hFF, 3);
    tv[14] = mk(8'h00, 8'h00, 0, 0, 1, 0, 8'h0F, 8'h00, 1, 8'hFF, 3);
    tv[15] = mk(8'hC3, 8'h30, 1, 0, 0, 0, 8'h0F, 8'h00, 1, 8'hFF, 3);
    tv[16] = mk(8'h00, 8'h00, 0, 0, 0, 0, 8'hC3, 8'h30, 1, 8'hFF, 3);
    tv[17] = mk(8'h00, 8'h00, 0, 0, 1, 1, 8'hC3, 8'h30, 1, 8'h30, 4);
    tv[18] = mk(8'h00, 8'h00, 0, 0, 1, 0, 8'hC3, 8'h30, 1, 8'h30, 5);
    tv[19] = mk(8'h00, 8'h00, 0, 0, 0, 1, 8'hC3, 8'h30, 0, 8'h00, 5);

    rst_n = 1'b0;
    drive(8'h3C, 8'hFF, 1, 1, 1, 0);
    repeat (2) @(negedge clk);
    check_outs("reset", 8'h00, 8'h00, 0, 8'h00, 0);
    drive(8'h00, 8'h00, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tv[i].d, tv[i].dt, tv[i].en, tv[i].ent, tv[i].chk, tv[i].clr);
      @(posedge clk);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), tv[i].q, tv[i].qt, tv[i].alarm, tv[i].leak, tv[i].cnt);
    end

    // Back-to-back strobes on q_t=30: one count per cycle, 2-bit counter pinned at 3.
    drive(8'h00, 8'h00, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_outs($sformatf("b2b%0d", k), 8'hC3, 8'h30, 1, 8'h30, 5 + k);
    end

    // Asynchronous reset between edges while the alarm is up.
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 8'h00, 8'h00, 0, 8'h00, 0);
    drive(8'h00, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation from zero: five tainted strobes.
    drive(8'h01, 8'h01, 1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(8'h01, 8'h01, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(8'h01, 8'h01, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      cmp($sformatf("sat%0d vcount2", k), 32'(if_b.vcount), 32'(sat(k, 3)));
      cmp($sformatf("sat%0d vcount8", k), 32'(if_a.vcount), 32'(k));
    end

    // Randomized run against the reference model, with one mid-run async reset.
    drive(8'h00, 8'h00, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 600; i++) begin
      logic [7:0] rd, rdt;
      logic       ren, rent, rchk, rclr;
      check_outs($sformatf("rnd%0d", i), m_d[DEPTH-1], m_t[DEPTH-1], m_alarm, m_leak, m_cnt);
      if (i == 300) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("rnd_rst", 8'h00, 8'h00, 0, 8'h00, 0);
        rst_n = 1'b1;
      end
      rd   = 8'($urandom);
      rdt  = 8'($urandom) & 8'($urandom);
      ren  = 1'($urandom_range(0, 1));
      rent = ($urandom_range(0, 3) == 0);
      rchk = 1'($urandom_range(0, 1));
      rclr = ($urandom_range(0, 3) == 0);
      drive(rd, rdt, ren, rent, rchk, rclr);
      @(posedge clk);
      model_step(rd, rdt, ren, rent, rchk, rclr);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
